// File: rtl/reg_alu_ctrl_if.sv
// Command handshake between a requester and reg_alu_ctrl.
//   cmd_valid/cmd_ready : one command moves on a rising edge where both are 1
//   cmd_kind            : 0 = ALU op (rd <- ra op rb), 1 = load-immediate
//   cmd_op/ra/rb/rd/imm : command payload, sampled only on acceptance
interface reg_alu_ctrl_if;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned DATA_W = 16;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_kind;
    logic [OP_W-1:0]   cmd_op;
    logic [ADDR_W-1:0] cmd_ra;
    logic [ADDR_W-1:0] cmd_rb;
    logic [ADDR_W-1:0] cmd_rd;
    logic [DATA_W-1:0] cmd_imm;

    modport master (
        output cmd_valid, cmd_kind, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_imm,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_kind, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_imm,
        output cmd_ready
    );
endinterface

// File: rtl/reg_alu_ctrl.sv
// Sequencer for a register-file/ALU datapath. Accepts one command at a time
// and walks IDLE -> READ -> EXEC -> WRITE (ALU) or IDLE -> WRITE (load-imm).
// Ports:
//   clk, reset (async, active-low)
//   cmd            : command handshake (slave side)
//   alu_cout       : datapath carry-out, sampled on the edge leaving EXEC
//   rd_addr_a/b, op: datapath read addresses / ALU opcode (captured command)
//   wr_addr, wr, sel, d_in : datapath write port controls
//   busy, done, carry, cmd_cnt : status
// Every output is a flop; control outputs are computed from the next state.
module reg_alu_ctrl (
    input  logic        clk,
    input  logic        reset,
    reg_alu_ctrl_if.slave cmd,
    input  logic        alu_cout,
    output logic [2:0]  rd_addr_a,
    output logic [2:0]  rd_addr_b,
    output logic [2:0]  wr_addr,
    output logic [1:0]  op,
    output logic        sel,
    output logic        wr,
    output logic [15:0] d_in,
    output logic        busy,
    output logic        done,
    output logic        carry,
    output logic [7:0]  cmd_cnt
);
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              kind_q, kind_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [ADDR_W-1:0] ra_q, ra_d;
    logic [ADDR_W-1:0] rb_q, rb_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic              carry_q, carry_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              wr_q, wr_d;
    logic              sel_q, sel_d;
    logic              accept_c;

    // Next-state, command capture and registered-output decode
    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        op_d     = op_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        rd_d     = rd_q;
        imm_d    = imm_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        accept_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    accept_c = 1'b1;
                    state_d  = cmd.cmd_kind ? WRITE : READ;
                end
            end
            READ:  state_d = EXEC;
            EXEC: begin
                state_d = WRITE;
                carry_d = alu_cout;
            end
            WRITE: begin
                state_d = IDLE;
                cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase

        if (accept_c) begin
            kind_d = cmd.cmd_kind;
            op_d   = cmd.cmd_op;
            ra_d   = cmd.cmd_ra;
            rb_d   = cmd.cmd_rb;
            rd_d   = cmd.cmd_rd;
            imm_d  = cmd.cmd_imm;
        end

        // Decoding from state_d lets these flops line up with the state they describe
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == WRITE);
        wr_d    = (state_d == WRITE);
        sel_d   = (state_d == WRITE) && !kind_d;
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            kind_q  <= 1'b0;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wr_q    <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            op_q    <= op_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rd_q    <= rd_d;
            imm_q   <= imm_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wr_q    <= wr_d;
            sel_q   <= sel_d;
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign rd_addr_a     = ra_q;
    assign rd_addr_b     = rb_q;
    assign op            = op_q;
    assign wr_addr       = rd_q;
    assign d_in          = imm_q;
    assign sel           = sel_q;
    assign wr            = wr_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign carry         = carry_q;
    assign cmd_cnt       = cnt_q;
endmodule

// File: doc/reg_alu_ctrl.md
REG_ALU_CTRL -- requirements
Module: reg_alu_ctrl

Interface
REQ-001 The block SHALL have exactly one clock, one reset, and the ports listed below.
- clk  in  1  rising-edge clock, sole clock.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  requester presents a command.
- cmd_ready  out  1  controller accepts a command this cycle.
- cmd_kind  in  1  0 = ALU op (rd <- ra op rb); 1 = load-immediate (rd <- cmd_imm).
- cmd_op  in  2  ALU operation code, passed to datapath op.
- cmd_ra  in  3  source register A address.
- cmd_rb  in  3  source register B address.
- cmd_rd  in  3  destination register address.
- cmd_imm  in  16  immediate data for load-immediate.
- alu_cout  in  1  carry-out from datapath ALU.
- rd_addr_a  out  3  datapath read address A.
- rd_addr_b  out  3  datapath read address B.
- wr_addr  out  3  datapath write address.
- op  out  2  datapath ALU operation.
- sel  out  1  write-data select: 1 = ALU result, 0 = d_in.
- wr  out  1  datapath register-file write enable.
- d_in  out  16  datapath write data for load-immediate.
- busy  out  1  command in flight.
- done  out  1  one-cycle pulse on command completion.
- carry  out  1  sticky copy of last ALU carry-out.
- cmd_cnt  out  8  count of completed commands.
REQ-002 All outputs SHALL be registered or decoded only from the state register; no combinational path from any input to any output.

Function
REQ-003 FSM states SHALL be IDLE, READ, EXEC, WRITE, binary-encoded.
REQ-004 cmd_ready SHALL be 1 in IDLE only; a command is accepted on a rising edge where cmd_valid=1 and cmd_ready=1.
REQ-005 On acceptance, all cmd_* fields SHALL be captured into internal registers; requester inputs are don't-care afterwards.
REQ-006 On acceptance, cmd_kind=0 SHALL transition IDLE->READ and cmd_kind=1 SHALL transition IDLE->WRITE.
REQ-007 READ->EXEC and EXEC->WRITE SHALL be unconditional; WRITE->IDLE SHALL be unconditional.
REQ-008 From READ through WRITE of an ALU command, rd_addr_a, rd_addr_b, op SHALL equal the captured ra, rb, op and hold stable.
REQ-009 In EXEC, carry SHALL load alu_cout on the clock edge leaving EXEC; load-immediate commands SHALL NOT modify carry.
REQ-010 In WRITE, wr=1, wr_addr=captured rd, and sel=1 for ALU commands, sel=0 with d_in=captured imm for load-immediate.
REQ-011 wr SHALL be 0 in every state other than WRITE; exactly one write per accepted command.
REQ-012 done SHALL be 1 exactly in the WRITE cycle; busy SHALL be 1 in READ, EXEC, WRITE.
REQ-013 cmd_cnt SHALL increment by 1 on the edge leaving WRITE and wrap 255->0.
REQ-014 Latency: ALU command accepted at edge N SHALL write at edge N+3; load-immediate at edge N+1; next acceptance no earlier than edge N+4 (ALU) or N+2 (load-immediate).
REQ-015 cmd_valid deasserted in IDLE SHALL leave all outputs unchanged.
REQ-016 Write to any address 0-7 SHALL be permitted, including rd equal to ra or rb.

Reset
REQ-017 reset=0 SHALL immediately force state IDLE, cmd_ready=1, wr=0, sel=0, done=0, busy=0, carry=0, cmd_cnt=0, all address/op/d_in outputs 0.
REQ-018 reset asserted mid-command SHALL abort it: no write, no done, cmd_cnt unchanged from 0.
REQ-019 After reset deasserts, the first acceptance SHALL occur no earlier than the next rising edge.

Verification
REQ-020 Reset, then load-immediate rd=3 imm=0x1234 -> one cycle later wr=1, sel=0, wr_addr=3, d_in=0x1234, done=1; cmd_cnt=1 after.
REQ-021 ALU cmd op=2 ra=1 rb=2 rd=5, alu_cout=1 in EXEC -> READ/EXEC/WRITE sequence, wr=1 sel=1 wr_addr=5 at edge N+3, carry=1.
REQ-022 cmd_valid held high with back-to-back ALU commands -> cmd_ready=1 only every 4th cycle, exactly one wr pulse per command.
REQ-023 Load-immediate after carry=1 -> carry stays 1; then ALU cmd with alu_cout=0 -> carry=0.
REQ-024 Issue 256 load-immediate commands -> cmd_cnt returns to 0.
REQ-025 Assert reset during EXEC -> wr never 1, done never 1, all outputs at reset values, next command accepted normally.
